// File: rtl/quat_delta_integrator_if.sv
// Delta-quaternion stream and orientation/status bus between the gyro delta stage and the integrator.
// Latency: none (wiring only).
// Backpressure: the source holds dq0..dq3 with dq_valid until it sees dq_ready at a rising edge.
//
// Signals:
//   init              load identity orientation / abort (source -> integrator)
//   dq_valid/dq_ready delta handshake
//   dq0..dq3          signed Q15 delta quaternion, scalar first
//   q0..q3            signed Q15 held orientation (registered)
//   q_valid           one-cycle pulse, q0..q3 just updated
//   busy, sat_flag    operation in progress / sticky saturation indicator
interface quat_delta_integrator_if;
    logic               init;
    logic               dq_valid;
    logic               dq_ready;
    logic signed [15:0] dq0;
    logic signed [15:0] dq1;
    logic signed [15:0] dq2;
    logic signed [15:0] dq3;
    logic signed [15:0] q0;
    logic signed [15:0] q1;
    logic signed [15:0] q2;
    logic signed [15:0] q3;
    logic               q_valid;
    logic               busy;
    logic               sat_flag;

    modport master (
        output init, dq_valid, dq0, dq1, dq2, dq3,
        input  dq_ready, q0, q1, q2, q3, q_valid, busy, sat_flag
    );

    modport slave (
        input  init, dq_valid, dq0, dq1, dq2, dq3,
        output dq_ready, q0, q1, q2, q3, q_valid, busy, sat_flag
    );
endinterface

// File: rtl/quat_delta_integrator.sv
// Integrates Q15 delta quaternions: q <- q (x) dq via one time-shared 16x16 MAC, Q15 round/saturate.
// Latency: q_valid in the cycle after the 17th edge following acceptance (26th with renormalisation).
// Backpressure: dq_ready only in IDLE without init; a delta offered while busy waits at the source.
//
// Ports: clk, rst (async, active high); bus (quat_delta_integrator_if.slave): init, dq_valid,
//        dq_ready, dq0..dq3 in, q0..q3 out, q_valid, busy, sat_flag.
// Optional feature macro: QUAT_RENORM_EN adds first-order renormalisation after each update
//        (NORM: 4 MAC cycles + 1 cycle for the scale factor, SCALE: 4 cycles).
module quat_delta_integrator #(
    parameter int ACC_W = 36
) (
    input  logic                    clk,
    input  logic                    rst,
    quat_delta_integrator_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC   = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
`ifdef QUAT_RENORM_EN
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_SCALE = 3'd4;
`endif

    logic [2:0]               state;
    logic [3:0]               idx;
    logic signed [15:0]       q   [4];
    logic signed [15:0]       d   [4];
    logic signed [15:0]       stg [4];
    logic signed [ACC_W-1:0]  acc;
    logic                     sat_flag;
    logic                     q_valid;

    // Round-half-up to Q15 and clamp to the symmetric range; bit 16 flags saturation.
    function automatic logic [16:0] round_sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] t;
        t = (v + ACC_W'(16384)) >>> 15;
        if (t > ACC_W'(32767))
            return {1'b1, 16'h7FFF};
        else if (t < -ACC_W'(32767))
            return {1'b1, 16'h8001};
        else
            return {1'b0, 16'(t)};
    endfunction

    // MAC operand selection. For Hamilton component c and term t the q operand is q[t]
    // and the dq operand is d[c ^ t]; six of the sixteen products enter negated.
    logic signed [15:0]      mac_a;
    logic signed [15:0]      mac_b;
    logic                    mac_neg;
    logic                    mac_first;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic [16:0]             mac_rs;

    always_comb begin
        mac_a     = q[idx[1:0]];
        mac_b     = d[idx[1:0] ^ idx[3:2]];
        mac_neg   = 1'b0;
        mac_first = (idx[1:0] == 2'd0);
        case (idx)
            4'd1, 4'd2, 4'd3, 4'd7, 4'd9, 4'd14: mac_neg = 1'b1;
            default: ;
        endcase
`ifdef QUAT_RENORM_EN
        // Norm pass: sum of squares of the freshly written q.
        if (state == S_NORM) begin
            mac_b     = q[idx[1:0]];
            mac_neg   = 1'b0;
            mac_first = (idx == 4'd0);
        end
`endif
        prod     = 32'(mac_a) * 32'(mac_b);
        prod_ext = ACC_W'(prod);
        acc_base = mac_first ? {ACC_W{1'b0}} : acc;
        acc_sum  = acc_base + (mac_neg ? -prod_ext : prod_ext);
        mac_rs   = round_sat(acc_sum);
    end

`ifdef QUAT_RENORM_EN
    // s = (3 - n)/2 in Q15 (about 1.0); n is in Q30 so the >>> 16 also halves.
    logic signed [16:0]      s_q15;
    logic signed [ACC_W-1:0] norm_diff;
    logic signed [32:0]      scl_prod;
    logic [16:0]             scl_rs;

    always_comb begin
        norm_diff = (ACC_W'(3) <<< 30) - acc;
        scl_prod  = 33'(q[idx[1:0]]) * 33'(s_q15);
        scl_rs    = round_sat(ACC_W'(scl_prod));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= 4'd0;
            acc      <= '0;
            sat_flag <= 1'b0;
            q_valid  <= 1'b0;
            q[0]     <= 16'sd32767;
            q[1]     <= 16'sd0;
            q[2]     <= 16'sd0;
            q[3]     <= 16'sd0;
            for (int i = 0; i < 4; i++) begin
                d[i]   <= 16'sd0;
                stg[i] <= 16'sd0;
            end
`ifdef QUAT_RENORM_EN
            s_q15    <= 17'sd0;
`endif
        end else begin
            q_valid <= 1'b0;
            if (bus.init) begin
                // Abort: partial results are dropped, no q_valid pulse.
                state    <= S_IDLE;
                idx      <= 4'd0;
                acc      <= '0;
                sat_flag <= 1'b0;
                q[0]     <= 16'sd32767;
                q[1]     <= 16'sd0;
                q[2]     <= 16'sd0;
                q[3]     <= 16'sd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.dq_valid) begin
                            d[0]  <= bus.dq0;
                            d[1]  <= bus.dq1;
                            d[2]  <= bus.dq2;
                            d[3]  <= bus.dq3;
                            idx   <= 4'd0;
                            state <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        acc <= acc_sum;
                        // Last term of a component: stage its rounded result.
                        if (idx[1:0] == 2'd3) begin
                            stg[idx[3:2]] <= mac_rs[15:0];
                            if (mac_rs[16])
                                sat_flag <= 1'b1;
                        end
                        if (idx == 4'd15) begin
                            idx   <= 4'd0;
                            state <= S_WR;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    S_WR: begin
                        for (int i = 0; i < 4; i++)
                            q[i] <= stg[i];
`ifdef QUAT_RENORM_EN
                        idx   <= 4'd0;
                        state <= S_NORM;
`else
                        q_valid <= 1'b1;
                        state   <= S_IDLE;
`endif
                    end
`ifdef QUAT_RENORM_EN
                    S_NORM: begin
                        if (idx != 4'd4) begin
                            acc <= acc_sum;
                            idx <= idx + 4'd1;
                        end else begin
                            s_q15 <= 17'(norm_diff >>> 16);
                            idx   <= 4'd0;
                            state <= S_SCALE;
                        end
                    end
                    S_SCALE: begin
                        q[idx[1:0]] <= scl_rs[15:0];
                        if (scl_rs[16])
                            sat_flag <= 1'b1;
                        if (idx == 4'd3) begin
                            idx     <= 4'd0;
                            q_valid <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.dq_ready = (state == S_IDLE) && !bus.init;
    assign bus.busy     = (state != S_IDLE);
    assign bus.q_valid  = q_valid;
    assign bus.sat_flag = sat_flag;
    assign bus.q0       = q[0];
    assign bus.q1       = q[1];
    assign bus.q2       = q[2];
    assign bus.q3       = q[3];

endmodule

// File: tb/tb_quat_delta_integrator.sv
// Bench for quat_delta_integrator: directed cases with literal expectations plus a randomized run
// checked every cycle against a quaternion-arithmetic reference model.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_quat_delta_integrator;

`ifdef QUAT_RENORM_EN
    localparam int LAT = 26;
    localparam int T2_Q0 = 32767;
`else
    localparam int LAT = 17;
    localparam int T2_Q0 = 32766;
`endif

    logic clk;
    logic rst;

    quat_delta_integrator_if bus();

    quat_delta_integrator #(.ACC_W(36)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  mq[4]  = '{32767, 0, 0, 0};
    bit  msat   = 1'b0;
    bit  mqv    = 1'b0;
    int  rem    = 0;      // edges left until the pending result lands
    int  pq[4];
    bit  psat;

    function automatic int rsat(input longint v, inout bit s);
        longint t;
        t = (v + 64'sd16384) >>> 15;
        if (t > 32767) begin s = 1'b1; return 32767; end
        if (t < -32767) begin s = 1'b1; return -32767; end
        return int'(t);
    endfunction

    task automatic model_compute(input int d0, input int d1, input int d2, input int d3);
        longint a0, a1, a2, a3, n, s;
        longint r[4];
        a0 = mq[0]; a1 = mq[1]; a2 = mq[2]; a3 = mq[3];
        r[0] = a0*d0 - a1*d1 - a2*d2 - a3*d3;
        r[1] = a0*d1 + a1*d0 + a2*d3 - a3*d2;
        r[2] = a0*d2 - a1*d3 + a2*d0 + a3*d1;
        r[3] = a0*d3 + a1*d2 - a2*d1 + a3*d0;
        psat = 1'b0;
        for (int i = 0; i < 4; i++) pq[i] = rsat(r[i], psat);
`ifdef QUAT_RENORM_EN
        n = 0;
        for (int i = 0; i < 4; i++) n += longint'(pq[i]) * pq[i];
        s = ((longint'(3) <<< 30) - n) >>> 16;
        for (int i = 0; i < 4; i++) pq[i] = rsat(longint'(pq[i]) * s, psat);
`else
        n = 0;
        s = n;
`endif
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq = '{32767, 0, 0, 0};
            msat = 1'b0; mqv = 1'b0; rem = 0;
        end else begin
            mqv = 1'b0;
            if (bus.init) begin
                mq = '{32767, 0, 0, 0};
                msat = 1'b0; rem = 0;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    mq = pq; msat = msat | psat; mqv = 1'b1;
                end
            end else if (bus.dq_valid) begin
                model_compute(int'(bus.dq0), int'(bus.dq1), int'(bus.dq2), int'(bus.dq3));
                rem = LAT;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("q_valid", int'(bus.q_valid), int'(mqv));
        chk("busy", int'(bus.busy), int'(rem > 0));
        chk("dq_ready", int'(bus.dq_ready), int'(rem == 0 && !bus.init));
        if (rem == 0) begin
            chk("q0", int'(bus.q0), mq[0]);
            chk("q1", int'(bus.q1), mq[1]);
            chk("q2", int'(bus.q2), mq[2]);
            chk("q3", int'(bus.q3), mq[3]);
            chk("sat_flag", int'(bus.sat_flag), int'(msat));
        end
    end

    // Handshake monitors (inputs are stable at the falling edge).
    int acc_cnt = 0;
    int qv_cnt  = 0;
    always @(negedge clk) begin
        if (!rst && bus.dq_valid && bus.dq_ready) acc_cnt++;
        if (bus.q_valid) qv_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dq(input int a, input int b, input int c, input int d);
        bus.dq0 = 16'(a); bus.dq1 = 16'(b); bus.dq2 = 16'(c); bus.dq3 = 16'(d);
    endtask

    // Offer one delta while idle; returns edges from acceptance to the q_valid cycle, or -1.
    task automatic send(input int a, input int b, input int c, input int d, output int lat);
        set_dq(a, b, c, d);
        bus.dq_valid = 1'b1;
        tick();
        bus.dq_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.q_valid) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("send_timeout", lat, LAT);
    endtask

    task automatic do_init();
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
    endtask

    function automatic int rnd_small();
        return $signed($urandom_range(0, 2000)) - 1000;
    endfunction

    task automatic rnd_dq();
        case ($urandom_range(0, 3))
            0: set_dq(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                      int'($signed(16'($urandom))), int'($signed(16'($urandom))));
            3: set_dq(32767, 0, 0, 0);
            default: set_dq(32767 - int'($urandom_range(0, 600)), rnd_small(), rnd_small(), rnd_small());
        endcase
    endtask

    // ---------------- main sequence ----------------
    int  lat;
    bit  will_acc;
    bit  seen;

    initial begin
        rst = 1'b1;
        bus.init = 1'b0;
        bus.dq_valid = 1'b0;
        set_dq(0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_q0", int'(bus.q0), 32767);
        chk("rst_q1", int'(bus.q1), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_qvalid", int'(bus.q_valid), 0);
        chk("rst_sat", int'(bus.sat_flag), 0);
        tick();
        rst = 1'b0;
        tick();

        // Identity times near-identity delta, latency pinned
        send(32767, 0, 0, 0, lat);
        chk("t2_latency", lat, LAT);
        chk("t2_q0", int'(bus.q0), T2_Q0);
        chk("t2_q1", int'(bus.q1), 0);
        tick();

        // 90-degree half-steps about x, then saturating step, then init
        do_init();
        send(23170, 23170, 0, 0, lat);
`ifndef QUAT_RENORM_EN
        chk("t4a_q0", int'(bus.q0), 23169);
        chk("t4a_q1", int'(bus.q1), 23169);
`endif
        tick();
        send(32767, 32767, 0, 0, lat);
`ifndef QUAT_RENORM_EN
        chk("t4b_q0", int'(bus.q0), 0);
        chk("t4b_q1", int'(bus.q1), 32767);
        chk("t4b_sat", int'(bus.sat_flag), 1);
`endif
        tick();
        do_init();
        @(negedge clk);
        chk("t4c_q0", int'(bus.q0), 32767);
        chk("t4c_sat", int'(bus.sat_flag), 0);
        tick();

        // init at MAC index 7 aborts; delta offered with init is refused
        set_dq(1000, 2000, -3000, 4000);
        bus.dq_valid = 1'b1;
        tick();                       // acceptance edge
        bus.dq_valid = 1'b0;
        repeat (7) tick();            // now at MAC index 7
        bus.init = 1'b1;
        bus.dq_valid = 1'b1;
        @(negedge clk);
        chk("t6_ready_init", int'(bus.dq_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_qvalid", int'(bus.q_valid), 0);
        chk("t6_q0", int'(bus.q0), 32767);
        chk("t6_q2", int'(bus.q2), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_no_accept", int'(bus.busy), 0);
        tick();
        bus.init = 1'b0;
        bus.dq_valid = 1'b0;
        tick();

        // Held dq_valid while busy: exactly one extra acceptance, on the q_valid cycle
        acc_cnt = 0;
        qv_cnt = 0;
        set_dq(32000, 1000, -500, 200);
        bus.dq_valid = 1'b1;
        tick();
        set_dq(31000, -2000, 700, 900);
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (bus.q_valid) begin
                seen = 1'b1;
                chk("t5_ready_on_qvalid", int'(bus.dq_ready), 1);
            end else if (bus.dq_ready) begin
                chk("t5_early_ready", int'(bus.dq_ready), 0);
            end
        end
        chk("t5_seen_qvalid", int'(seen), 1);
        tick();
        bus.dq_valid = 1'b0;
        for (int n = 0; n < 60 && bus.busy; n++) @(negedge clk);
        tick();
        tick();
        chk("t5_accepts", acc_cnt, 2);
        chk("t5_qvalids", qv_cnt, 2);

        // Reset pulse mid-MAC
        set_dq(20000, 10000, -10000, 5000);
        bus.dq_valid = 1'b1;
        tick();
        bus.dq_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("t1_q0", int'(bus.q0), 32767);
        chk("t1_q3", int'(bus.q3), 0);
        chk("t1_busy", int'(bus.busy), 0);
        chk("t1_qvalid", int'(bus.q_valid), 0);
        chk("t1_ready", int'(bus.dq_ready), 1);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic with occasional init
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            will_acc = bus.dq_valid && bus.dq_ready;
            @(posedge clk);
            #1;
            bus.init = ($urandom_range(0, 120) == 0);
            if (will_acc) begin
                if ($urandom_range(0, 1) == 1) rnd_dq();
                else bus.dq_valid = 1'b0;
            end else if (!bus.dq_valid && $urandom_range(0, 2) == 0) begin
                rnd_dq();
                bus.dq_valid = 1'b1;
            end
        end
        bus.dq_valid = 1'b0;
        bus.init = 1'b0;
        for (int n = 0; n < 60 && bus.busy; n++) @(negedge clk);
        @(negedge clk);
        chk("final_idle", int'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
